// File: rtl/mdc_feeder.sv
// Operand-pair FIFO and handshake sequencer feeding a GCD core.
// Issues one pair at a time and holds each result until it is accepted.
module mdc_feeder #(
  parameter int DEPTH = 4,
  parameter int TMO   = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [7:0] in_x_i,
  input  logic [7:0] in_y_i,
  output logic       enb_o,
  output logic [7:0] dtx_o,
  output logic [7:0] dty_o,
  input  logic       busy_i,
  input  logic [7:0] dt_i,
  output logic       res_valid_o,
  input  logic       res_ready_i,
  output logic [7:0] res_dt_o,
  output logic [7:0] res_x_o,
  output logic [7:0] res_y_o,
  output logic       res_tmo_o,
  output logic [4:0] count_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    HOLD
  } state_t;

  state_t state, state_d;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [4:0]    count;
  logic [7:0]    tmo_cnt;
  logic [7:0]    op_x, op_y;
  logic [7:0]    r_dt, r_x, r_y;
  logic          r_tmo;

  logic push, pop, cap, cap_tmo;

  assign in_ready_o  = (count != 5'(DEPTH));
  assign push        = in_valid_i && in_ready_o;
  assign count_o     = count;
  assign enb_o       = (state == ISSUE);
  assign res_valid_o = (state == HOLD);
  assign dtx_o       = op_x;
  assign dty_o       = op_y;
  assign res_dt_o    = r_dt;
  assign res_x_o     = r_x;
  assign res_y_o     = r_y;
  assign res_tmo_o   = r_tmo;

  always_comb begin
    state_d = state;
    pop     = 1'b0;
    cap     = 1'b0;
    cap_tmo = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != 5'd0 && !busy_i) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (busy_i) begin
          state_d = WAIT_DONE;
        end else if (tmo_cnt == 8'(TMO - 1)) begin
          cap     = 1'b1;
          cap_tmo = 1'b1;
          state_d = HOLD;
        end
      end
      WAIT_DONE: begin
        if (!busy_i) begin
          cap     = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (res_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Storage has no reset; occupancy and pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= {in_x_i, in_y_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= 5'd0;
      tmo_cnt <= 8'd0;
      op_x    <= 8'd0;
      op_y    <= 8'd0;
      r_dt    <= 8'd0;
      r_x     <= 8'd0;
      r_y     <= 8'd0;
      r_tmo   <= 1'b0;
    end else begin
      state <= state_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 5'd1;
      else if (pop && !push) count <= count - 5'd1;
      if (state == WAIT_BUSY && !busy_i) tmo_cnt <= tmo_cnt + 8'd1;
      else                               tmo_cnt <= 8'd0;
      if (pop) begin
        op_x <= mem[rd_ptr][15:8];
        op_y <= mem[rd_ptr][7:0];
      end
      if (cap) begin
        r_dt  <= dt_i;
        r_x   <= op_x;
        r_y   <= op_y;
        r_tmo <= cap_tmo;
      end
    end
  end

endmodule

// File: tb/tb_mdc_feeder.sv
// Directed bench for mdc_feeder with a behavioural GCD core.
// Core busy length, stuck-busy and never-busy modes are bench-controlled.
module tb_mdc_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_x, in_y;
  logic       enb;
  logic [7:0] dtx, dty;
  logic       busy;
  logic [7:0] dt;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_dt, res_x, res_y;
  logic       res_tmo;
  logic [4:0] count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mdc_feeder #(.DEPTH(4), .TMO(3)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_x_i(in_x), .in_y_i(in_y),
    .enb_o(enb), .dtx_o(dtx), .dty_o(dty),
    .busy_i(busy), .dt_i(dt),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_dt_o(res_dt), .res_x_o(res_x), .res_y_o(res_y),
    .res_tmo_o(res_tmo), .count_o(count)
  );

  function automatic logic [7:0] gcd8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, q, t;
    p = a;
    q = b;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  // Core model: busy starts the cycle after enb, lasts busy_len cycles.
  int         busy_len = 5;
  int         core_cnt = 0;
  logic       core_hold = 1'b0;
  logic       core_never = 1'b0;
  logic [7:0] core_res = 8'd0;
  int         enb_cnt = 0;

  always @(posedge clk) begin
    if (enb) enb_cnt <= enb_cnt + 1;
    if (enb && !core_never) begin
      core_cnt <= busy_len;
      core_res <= gcd8(dtx, dty);
    end else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
    end
  end

  assign busy = core_hold || (core_cnt != 0);
  assign dt   = core_never ? 8'h2A : core_res;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] x, input logic [7:0] y);
    in_valid = 1'b1;
    in_x = x;
    in_y = y;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input int max);
    int n;
    n = 0;
    while (!res_valid && n < max) begin
      step();
      n++;
    end
    chk("res_wait", 32'(res_valid), 32'd1);
  endtask

  task automatic accept();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic expect_res(input string tag, input logic [7:0] d,
                            input logic [7:0] x, input logic [7:0] y, input logic t);
    wait_res(60);
    chk({tag, "_dt"}, 32'(res_dt), 32'(d));
    chk({tag, "_x"}, 32'(res_x), 32'(x));
    chk({tag, "_y"}, 32'(res_y), 32'(y));
    chk({tag, "_tmo"}, 32'(res_tmo), 32'(t));
    accept();
  endtask

  initial begin
    logic [7:0] fx [5];
    logic [7:0] fy [5];
    logic [7:0] fd [5];
    logic [7:0] s_dt, s_x, s_y;
    logic       s_tmo, stable, took;
    int e0, n;

    rst = 1'b1;
    in_valid = 1'b0;
    in_x = 8'd0;
    in_y = 8'd0;
    res_ready = 1'b0;
    step();
    step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_enb", 32'(enb), 32'd0);
    chk("rst_ops", 32'({dtx, dty}), 32'd0);
    chk("rst_res", 32'({res_dt, res_x, res_y, 7'd0, res_tmo}), 32'd0);
    rst = 1'b0;
    step();

    // Single operation
    e0 = enb_cnt;
    push(8'd12, 8'd18);
    expect_res("single", 8'd6, 8'd12, 8'd18, 1'b0);
    chk("single_enb", 32'(enb_cnt - e0), 32'd1);
    chk("single_after", 32'(res_valid), 32'd0);

    // Full FIFO while the core is held busy
    fx[0] = 8'd12; fy[0] = 8'd18; fd[0] = 8'd6;
    fx[1] = 8'd20; fy[1] = 8'd8;  fd[1] = 8'd4;
    fx[2] = 8'd9;  fy[2] = 8'd6;  fd[2] = 8'd3;
    fx[3] = 8'd0;  fy[3] = 8'd7;  fd[3] = 8'd7;
    fx[4] = 8'd35; fy[4] = 8'd21; fd[4] = 8'd7;
    core_hold = 1'b1;
    for (int i = 0; i < 4; i++) push(fx[i], fy[i]);
    in_valid = 1'b1;
    in_x = fx[4];
    in_y = fy[4];
    step();
    step();
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(in_ready), 32'd0);
    core_hold = 1'b0;
    took = 1'b0;
    n = 0;
    while (!took && n < 10) begin
      took = in_ready;
      step();
      n++;
    end
    in_valid = 1'b0;
    chk("full_fifth_taken", 32'(took), 32'd1);
    chk("full_wrap_count", 32'(count), 32'd4);
    for (int i = 0; i < 5; i++) expect_res("full", fd[i], fx[i], fy[i], 1'b0);

    // Backpressure, then a push in the same cycle as a pop
    busy_len = 2;
    push(8'd48, 8'd36);
    push(8'd14, 8'd21);
    wait_res(40);
    s_dt = res_dt;
    s_x = res_x;
    s_y = res_y;
    s_tmo = res_tmo;
    e0 = enb_cnt;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!res_valid || res_dt != s_dt || res_x != s_x ||
          res_y != s_y || res_tmo != s_tmo) stable = 1'b0;
    end
    chk("bp_stable", 32'(stable), 32'd1);
    chk("bp_no_enb", 32'(enb_cnt - e0), 32'd0);
    chk("bp_dt", 32'(s_dt), 32'd12);
    accept();
    chk("bp_count_pre", 32'(count), 32'd1);
    push(8'd10, 8'd4);
    chk("pushpop_count", 32'(count), 32'd1);
    expect_res("bp2", 8'd7, 8'd14, 8'd21, 1'b0);
    expect_res("bp3", 8'd2, 8'd10, 8'd4, 1'b0);

    // Timeout: core never raises busy
    core_never = 1'b1;
    push(8'd5, 8'd10);
    n = 0;
    while (!enb && n < 10) begin
      step();
      n++;
    end
    chk("tmo_enb", 32'(enb), 32'd1);
    n = 0;
    while (!res_valid && n < 20) begin
      step();
      n++;
    end
    chk("tmo_latency", 32'(n), 32'd4);
    expect_res("tmo", 8'h2A, 8'd5, 8'd10, 1'b1);
    core_never = 1'b0;

    // Reset while waiting for the core to finish
    busy_len = 20;
    push(8'd6, 8'd9);
    push(8'd8, 8'd12);
    push(8'd15, 8'd25);
    push(8'd7, 8'd7);
    step();
    chk("mid_count", 32'(count), 32'd3);
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_ops", 32'({dtx, dty}), 32'd0);
    e0 = enb_cnt;
    stable = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (res_valid) stable = 1'b0;
    end
    chk("mid_no_enb", 32'(enb_cnt - e0), 32'd0);
    chk("mid_no_valid", 32'(stable), 32'd1);
    busy_len = 3;
    push(8'd27, 8'd18);
    expect_res("post_rst", 8'd9, 8'd27, 8'd18, 1'b0);
    chk("post_rst_enb", 32'(enb_cnt - e0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
